inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, the PC loaded on reset (word-aligned).
REQ-002 Parameter TIMEOUT_CYCLES, default 16, the wait-for-ack limit used only when IFETCH_TIMEOUT_EN is defined.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  32  fetch address; equals the current PC.
REQ-007 imem_ack  input  1  memory has valid imem_rdata this cycle.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 stall  input  1  downstream cannot accept; hold the current instruction.
REQ-010 branch  input  1  Branch control from the decode/control stage for the current instruction.
REQ-011 alu_zero  input  1  ALU zero flag for the current instruction.
REQ-012 jump  input  1  Jump control for the current instruction.
REQ-013 instr  output  32  captured instruction register.
REQ-014 op_code  output  6  instr[31:26], feeds the control unit OpCode.
REQ-015 funct  output  6  instr[5:0], feeds the control unit Funct.
REQ-016 pc_out  output  32  PC of the instruction in instr.
REQ-017 instr_valid  output  1  instr/op_code/funct/pc_out are valid this cycle.
REQ-018 fetch_err  output  1  sticky fetch-timeout flag (constant 0 when IFETCH_TIMEOUT_EN is undefined).

Function
REQ-019 The FSM SHALL have states IDLE, FETCH, VALID; IDLE->FETCH unconditionally on the first edge with rst_n=1.
REQ-020 imem_req SHALL be 1 exactly while state==FETCH; imem_addr SHALL equal pc and stay stable while imem_req=1.
REQ-021 In FETCH with imem_ack=1, imem_rdata SHALL be captured into instr and the FSM SHALL go to VALID; imem_ack outside FETCH SHALL be ignored.
REQ-022 instr_valid SHALL be 1 exactly while state==VALID; stall is ignored in FETCH.
REQ-023 In VALID with stall=1, the FSM, pc and instr SHALL hold unchanged.
REQ-024 In VALID with stall=0 (advance), pc SHALL load next_pc and the FSM SHALL go to FETCH; branch, alu_zero, jump are sampled only on this edge.
REQ-025 next_pc priority: jump -> {pc+4[31:28], instr[25:0], 2'b00}; else branch&&alu_zero -> pc+4 + (sign_ext(instr[15:0])<<2); else pc+4.
REQ-026 All PC arithmetic SHALL be 32-bit modulo 2^32 (0xFFFF_FFFC+4 = 0x0000_0000); pc[1:0] SHALL always be 2'b00.
REQ-027 Minimum fetch-to-fetch throughput SHALL be 2 cycles per instruction (one FETCH cycle with immediate ack, one VALID cycle).

Reset
REQ-028 While rst_n=0 at an edge: state=IDLE, pc=RESET_PC, instr=0, fetch_err=0; hence imem_req=0, instr_valid=0, op_code=0, funct=0.
REQ-029 Reset asserted mid-fetch SHALL abandon the outstanding request; a late imem_ack after reset SHALL be ignored.

Configuration
REQ-030 With IFETCH_TIMEOUT_EN defined, a wait counter SHALL count cycles in FETCH without ack; on reaching TIMEOUT_CYCLES, fetch_err SHALL set (sticky until reset), the counter SHALL clear and the request SHALL continue at the same address.
REQ-031 Without IFETCH_TIMEOUT_EN, no counter SHALL be built and fetch_err SHALL be tied to 0; FETCH waits indefinitely.

Structure
REQ-032 A shared package cpu_pkg SHALL hold the FSM state encoding, the RESET_PC default and the instruction field bit positions (op, funct, imm16, target26).
REQ-033 Next-PC computation SHALL be a combinational sub-module next_pc (inputs pc, instr, branch, alu_zero, jump; output next_pc).

Verification
REQ-034 Reset release, ack on the first FETCH cycle, rdata 0x0000_0020 -> imem_req at addr 0 one cycle after release; next cycle instr_valid=1, op_code=0, funct=0x20, pc_out=0.
REQ-035 Advance with stall=0, no branch/jump, pc=0x10 -> next imem_addr=0x14.
REQ-036 instr=0x1000_FFFF at pc=0x40, branch=1, alu_zero=1 -> next addr 0x40; with alu_zero=0 -> 0x44.
REQ-037 instr=0x0800_0010 at pc=0x8000_0000, jump=1 and branch=1 -> next addr 0x8000_0040 (jump wins).
REQ-038 stall=1 held 5 cycles in VALID -> instr, pc_out unchanged and imem_req=0 throughout; the cycle after stall drops, FETCH of pc+4.
REQ-039 With IFETCH_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ack -> fetch_err=1 after 16 FETCH cycles, address unchanged; rst_n=0 for one edge -> fetch_err=0, imem_req=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: FSM encoding, reset PC default, instruction field positions
// and the branch-offset helper.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam int unsigned OP_HI     = 31;
    localparam int unsigned OP_LO     = 26;
    localparam int unsigned FUNCT_HI  = 5;
    localparam int unsigned FUNCT_LO  = 0;
    localparam int unsigned IMM_HI    = 15;
    localparam int unsigned IMM_LO    = 0;
    localparam int unsigned TARGET_HI = 25;
    localparam int unsigned TARGET_LO = 0;

    // Word offset of a 16-bit branch immediate, sign-extended to a byte offset.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage and instruction memory.
interface inst_fetch_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, addr, input ack, rdata);
    modport slave  (input req, addr, output ack, rdata);
endinterface

// File: rtl/next_pc.sv
// Combinational next-PC selection: jump beats taken branch beats sequential pc+4.
module next_pc
    import cpu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic        branch,
    input  logic        alu_zero,
    input  logic        jump,
    output logic [31:0] next_pc
);
    logic [31:0] pc_plus4;
    logic        unused_op;

    assign pc_plus4  = pc + 32'd4;
    assign unused_op = ^instr[OP_HI:OP_LO];

    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = {pc_plus4[31:28], instr[TARGET_HI:TARGET_LO], 2'b00};
        end else if (branch && alu_zero) begin
            next_pc = pc_plus4 + branch_offset(instr[IMM_HI:IMM_LO]);
        end
    end
endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: IDLE/FETCH/VALID handshake with instruction memory.
// Optional fetch timeout flag is built only when IFETCH_TIMEOUT_EN is defined.
module inst_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = RESET_PC_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    inst_fetch_if.master imem,
    input  logic         stall,
    input  logic         branch,
    input  logic         alu_zero,
    input  logic         jump,
    output logic [31:0]  instr,
    output logic [5:0]   op_code,
    output logic [5:0]   funct,
    output logic [31:0]  pc_out,
    output logic         instr_valid,
    output logic         fetch_err
);
    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  npc;
    logic         req_q;
    logic         valid_q;

    next_pc u_next_pc (
        .pc       (pc),
        .instr    (instr),
        .branch   (branch),
        .alu_zero (alu_zero),
        .jump     (jump),
        .next_pc  (npc)
    );

    // req/valid are registered alongside the state so they mirror FETCH/VALID exactly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            pc      <= {RESET_PC[31:2], 2'b00};
            instr   <= '0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    state <= FETCH;
                    req_q <= 1'b1;
                end
                FETCH: begin
                    if (imem.ack) begin
                        instr   <= imem.rdata;
                        state   <= VALID;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                    end
                end
                VALID: begin
                    if (!stall) begin
                        pc      <= {npc[31:2], 2'b00};
                        state   <= FETCH;
                        req_q   <= 1'b1;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem.req    = req_q;
    assign imem.addr   = pc;
    assign instr_valid = valid_q;
    assign pc_out      = pc;
    assign op_code     = instr[OP_HI:OP_LO];
    assign funct       = instr[FUNCT_HI:FUNCT_LO];

`ifdef IFETCH_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wait_cnt;
    logic          err_q;

    // The request keeps going after a timeout; only the sticky flag records it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else if (state == FETCH && !imem.ack) begin
            if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                wait_cnt <= '0;
                err_q    <= 1'b1;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end else begin
            wait_cnt <= '0;
        end
    end

    assign fetch_err = err_q;
`else
    logic [31:0] unused_timeout;

    assign unused_timeout = TIMEOUT_CYCLES;
    assign fetch_err      = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: transaction-level model plus directed vectors.
module tb_inst_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          TO       = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stall = 1'b1, branch = 1'b0, alu_zero = 1'b0, jump = 1'b0;
    logic ack_auto = 1'b1, ack_force = 1'b0;
    logic [31:0] instr, pc_out;
    logic [5:0]  op_code, funct;
    logic        instr_valid, fetch_err;
    logic [31:0] mem [256];

    logic stall2 = 1'b1, branch2 = 1'b0, alu_zero2 = 1'b0, jump2 = 1'b0;
    logic [31:0] instr2, pc_out2;
    logic [5:0]  op_code2, funct2;
    logic        instr_valid2, fetch_err2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    inst_fetch_if bus ();
    inst_fetch_if bus2 ();

    assign bus.ack    = ack_force | (ack_auto & bus.req);
    assign bus.rdata  = mem[bus.addr[9:2]];
    assign bus2.ack   = bus2.req;
    assign bus2.rdata = 32'h0800_0010;

    inst_fetch #(.RESET_PC(RESET_PC), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .imem(bus), .stall(stall), .branch(branch),
        .alu_zero(alu_zero), .jump(jump), .instr(instr), .op_code(op_code), .funct(funct),
        .pc_out(pc_out), .instr_valid(instr_valid), .fetch_err(fetch_err)
    );

    inst_fetch #(.RESET_PC(32'h8000_0000), .TIMEOUT_CYCLES(TO)) dut2 (
        .clk(clk), .rst_n(rst_n), .imem(bus2), .stall(stall2), .branch(branch2),
        .alu_zero(alu_zero2), .jump(jump2), .instr(instr2), .op_code(op_code2), .funct(funct2),
        .pc_out(pc_out2), .instr_valid(instr_valid2), .fetch_err(fetch_err2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Where the PC goes after an instruction retires, straight from the ISA rules.
    function automatic logic [31:0] predict(input logic [31:0] pc, input logic [31:0] ins,
                                            input logic br, input logic z, input logic j);
        logic [31:0] seq;
        logic [15:0] imm;
        int          off;
        seq = pc + 32'd4;
        imm = ins[15:0];
        off = int'($signed(imm));
        if (j) return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
        if (br && z) return seq + 32'(off * 4);
        return seq;
    endfunction

    // Model: "waiting for memory" / "holding an instruction" / "just out of reset".
    logic        m_started = 1'b0;
    logic        m_req, m_valid, m_err;
    logic [31:0] m_pc, m_instr;
    int          m_wait;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_req = 1'b0; m_valid = 1'b0; m_err = 1'b0; m_wait = 0;
            m_pc = RESET_PC; m_instr = 32'h0; m_started = 1'b1;
        end else if (m_started) begin
            if (m_req) begin
                if (ack_force || ack_auto) begin
                    m_instr = mem[m_pc[9:2]];
                    m_req = 1'b0; m_valid = 1'b1; m_wait = 0;
                end else begin
                    m_wait++;
`ifdef IFETCH_TIMEOUT_EN
                    if (m_wait == TO) begin m_err = 1'b1; m_wait = 0; end
`endif
                end
            end else if (m_valid) begin
                if (!stall) begin
                    m_pc = predict(m_pc, m_instr, branch, alu_zero, jump);
                    m_valid = 1'b0; m_req = 1'b1;
                end
            end else begin
                m_req = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            check("m_req", {31'b0, bus.req}, {31'b0, m_req});
            check("m_valid", {31'b0, instr_valid}, {31'b0, m_valid});
            check("m_addr", bus.addr, m_pc);
            check("m_pc_out", pc_out, m_pc);
            check("m_instr", instr, m_instr);
            check("m_op_code", {26'b0, op_code}, {26'b0, m_instr[31:26]});
            check("m_funct", {26'b0, funct}, {26'b0, m_instr[5:0]});
            check("m_fetch_err", {31'b0, fetch_err}, {31'b0, m_err});
        end
    end

    task automatic wait_valid();
        int n = 0;
        while (instr_valid !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (instr_valid !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wait_valid: instr_valid stuck at %b, expected 1", instr_valid);
        end
    endtask

    // Release stall for one edge with the given controls; then the next fetch must be at exp.
    task automatic advance(input logic b, input logic z, input logic j, input logic [31:0] exp,
                           input string name);
        wait_valid();
        stall = 1'b0; branch = b; alu_zero = z; jump = j;
        @(negedge clk);
        stall = 1'b1; branch = 1'b0; alu_zero = 1'b0; jump = 1'b0;
        check({name, "_addr"}, bus.addr, exp);
        check({name, "_req"}, {31'b0, bus.req}, 32'd1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0020;
        mem[5]  = 32'h0800_0010;
        mem[16] = 32'h1000_FFFF;
        mem[17] = 32'h2222_0020;
        mem[18] = 32'h1000_FFEC;

        check("pin_branch_taken", predict(32'h40, 32'h1000_FFFF, 1'b1, 1'b1, 1'b0), 32'h40);
        check("pin_branch_not", predict(32'h40, 32'h1000_FFFF, 1'b1, 1'b0, 1'b0), 32'h44);
        check("pin_jump_wins", predict(32'h8000_0000, 32'h0800_0010, 1'b1, 1'b1, 1'b1),
              32'h8000_0040);
        check("pin_wrap", predict(32'hFFFF_FFFC, 32'h0000_0020, 1'b0, 1'b0, 1'b0), 32'h0);

        repeat (3) @(negedge clk);
        check("rst_req", {31'b0, bus.req}, 32'd0);
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_op_funct", {20'b0, op_code, funct}, 32'd0);
        check("rst_err", {31'b0, fetch_err}, 32'd0);
        check("rst_pc", pc_out, 32'h0);

        rst_n = 1'b1;
        @(negedge clk);
        check("first_req", {31'b0, bus.req}, 32'd1);
        check("first_addr", bus.addr, 32'h0);
        @(negedge clk);
        check("first_valid", {31'b0, instr_valid}, 32'd1);
        check("first_op", {26'b0, op_code}, 32'h0);
        check("first_funct", {26'b0, funct}, 32'h20);
        check("first_pc", pc_out, 32'h0);

        check("j2_valid", {31'b0, instr_valid2}, 32'd1);
        check("j2_pc", pc_out2, 32'h8000_0000);
        stall2 = 1'b0; jump2 = 1'b1; branch2 = 1'b1; alu_zero2 = 1'b1;
        @(negedge clk);
        stall2 = 1'b1; jump2 = 1'b0; branch2 = 1'b0; alu_zero2 = 1'b0;
        check("j2_addr", bus2.addr, 32'h8000_0040);
        check("j2_req", {31'b0, bus2.req}, 32'd1);

        advance(1'b0, 1'b0, 1'b0, 32'h04, "seq4");
        advance(1'b0, 1'b0, 1'b0, 32'h08, "seq8");
        advance(1'b0, 1'b0, 1'b0, 32'h0C, "seqC");
        advance(1'b0, 1'b0, 1'b0, 32'h10, "seq10");
        advance(1'b0, 1'b0, 1'b0, 32'h14, "seq14");
        advance(1'b0, 1'b0, 1'b1, 32'h40, "jump40");
        advance(1'b1, 1'b1, 1'b0, 32'h40, "br_taken");
        advance(1'b1, 1'b0, 1'b0, 32'h44, "br_not");

        // Hold in VALID; a stray ack here must not disturb anything.
        wait_valid();
        ack_force = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_instr", instr, 32'h2222_0020);
            check("stall_pc", pc_out, 32'h44);
            check("stall_req", {31'b0, bus.req}, 32'd0);
            check("stall_valid", {31'b0, instr_valid}, 32'd1);
        end
        ack_force = 1'b0;
        advance(1'b0, 1'b0, 1'b0, 32'h48, "stall_release");
        advance(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, "br_back");
        advance(1'b0, 1'b0, 1'b0, 32'h0, "wrap");

        wait_valid();
        ack_auto = 1'b0;
        advance(1'b0, 1'b0, 1'b0, 32'h04, "noack_start");
        repeat (TO - 1) @(negedge clk);
        check("to_err_before", {31'b0, fetch_err}, 32'd0);
        @(negedge clk);
`ifdef IFETCH_TIMEOUT_EN
        check("to_err_set", {31'b0, fetch_err}, 32'd1);
`else
        check("to_err_tied", {31'b0, fetch_err}, 32'd0);
`endif
        repeat (4) @(negedge clk);
        check("to_addr_held", bus.addr, 32'h04);
        check("to_req_held", {31'b0, bus.req}, 32'd1);

        // Reset mid-fetch with a late ack that must be ignored while idle.
        rst_n = 1'b0;
        ack_force = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst2_err", {31'b0, fetch_err}, 32'd0);
        check("rst2_req", {31'b0, bus.req}, 32'd0);
        check("rst2_valid", {31'b0, instr_valid}, 32'd0);
        @(negedge clk);
        check("rst2_fetch_addr", bus.addr, 32'h0);
        @(negedge clk);
        check("rst2_refetch", instr, 32'h0000_0020);
        ack_force = 1'b0;
        ack_auto = 1'b1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
